// File: rtl/axis_frame_encoder.sv
// -----------------------------------------------------------------------------
// axis_frame_encoder
//
// Byte-wide AXI4-Stream frame encoder for the TX side of the framing layer.
// Each input packet is wrapped as START_BYTE, payload, STOP_BYTE. Any payload
// byte equal to one of the three marker bytes is sent as ESCAPE_BYTE followed
// by (byte ^ XOR_MASK). The receiving decoder drops ESCAPE_BYTE and XORs the
// next byte with XOR_MASK. The output is a single register stage, so the
// encoder sustains one byte per cycle.
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   target_*           AXI4-Stream input (tvalid/tready/tdata/tlast)
//   initiator_*        AXI4-Stream output, registered; tlast marks STOP_BYTE
//   frame_count        completed frames (STOP handshakes), wraps
//   escape_count       inserted escape bytes, wraps
//   busy               encoder FSM is not idle
// -----------------------------------------------------------------------------
module axis_frame_encoder #(
    parameter logic [7:0] ESCAPE_BYTE = 8'h7F,
    parameter logic [7:0] START_BYTE  = 8'h7D,
    parameter logic [7:0] STOP_BYTE   = 8'h7E,
    parameter logic [7:0] XOR_MASK    = 8'h00,
    parameter int         CNT_WIDTH   = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 target_tvalid,
    output logic                 target_tready,
    input  logic [7:0]           target_tdata,
    input  logic                 target_tlast,
    output logic                 initiator_tvalid,
    input  logic                 initiator_tready,
    output logic [7:0]           initiator_tdata,
    output logic                 initiator_tlast,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] escape_count,
    output logic                 busy
);

    // The decoder could not tell markers apart if any two were equal.
    if ((START_BYTE == STOP_BYTE) || (START_BYTE == ESCAPE_BYTE) ||
        (STOP_BYTE == ESCAPE_BYTE)) begin : g_marker_check
        $fatal(1, "axis_frame_encoder: START/STOP/ESCAPE bytes must be distinct");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ESC  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // True when a payload byte collides with a framing marker.
    function automatic logic is_marker(input logic [7:0] b);
        is_marker = (b == START_BYTE) || (b == STOP_BYTE) || (b == ESCAPE_BYTE);
    endfunction

    state_t                 state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]   esc_cnt_q, esc_cnt_d;

    logic                   load_s;
    logic                   match_s;
    logic                   emit_s;
    logic [7:0]             emit_data_s;
    logic                   emit_last_s;
    logic                   tready_s;
    logic                   esc_inc_s;

    // The output register can take a new beat when empty or being drained.
    assign load_s  = !out_valid_q || initiator_tready;
    assign match_s = is_marker(target_tdata);

    // FSM next state, emit strobe/byte and input ready.
    always_comb begin
        state_d     = state_q;
        emit_s      = 1'b0;
        emit_data_s = 8'h00;
        emit_last_s = 1'b0;
        tready_s    = 1'b0;
        esc_inc_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // START goes out without consuming the first payload byte.
                if (load_s && target_tvalid) begin
                    emit_s      = 1'b1;
                    emit_data_s = START_BYTE;
                    state_d     = ST_DATA;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (load_s && target_tvalid && match_s) begin
                    // Escape prefix first; the byte itself stays held upstream.
                    emit_s      = 1'b1;
                    emit_data_s = ESCAPE_BYTE;
                    esc_inc_s   = 1'b1;
                    state_d     = ST_ESC;
                end else if (load_s && target_tvalid) begin
                    emit_s      = 1'b1;
                    emit_data_s = target_tdata;
                    tready_s    = 1'b1;
                    state_d     = target_tlast ? ST_STOP : ST_DATA;
                end else begin
                    state_d     = ST_DATA;
                end
            end
            ST_ESC: begin
                // Input is still valid here: it was not accepted in DATA.
                if (load_s) begin
                    emit_s      = 1'b1;
                    emit_data_s = target_tdata ^ XOR_MASK;
                    tready_s    = 1'b1;
                    state_d     = target_tlast ? ST_STOP : ST_DATA;
                end else begin
                    state_d     = ST_ESC;
                end
            end
            ST_STOP: begin
                if (load_s) begin
                    emit_s      = 1'b1;
                    emit_data_s = STOP_BYTE;
                    emit_last_s = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register and statistics counters next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        frame_cnt_d = frame_cnt_q;
        esc_cnt_d   = esc_cnt_q;
        if (load_s) begin
            out_valid_d = emit_s;
            // Data/last hold their old value on bubbles so a stall never glitches.
            if (emit_s) begin
                out_data_d = emit_data_s;
                out_last_d = emit_last_s;
            end else begin
                out_data_d = out_data_q;
                out_last_d = out_last_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
        if (out_valid_q && initiator_tready && out_last_q) begin
            frame_cnt_d = frame_cnt_q + CNT_ONE;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        if (esc_inc_s) begin
            esc_cnt_d = esc_cnt_q + CNT_ONE;
        end else begin
            esc_cnt_d = esc_cnt_q;
        end
    end

    // State, output and counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            frame_cnt_q <= {CNT_WIDTH{1'b0}};
            esc_cnt_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            frame_cnt_q <= frame_cnt_d;
            esc_cnt_q   <= esc_cnt_d;
        end
    end

    assign target_tready    = tready_s;
    assign initiator_tvalid = out_valid_q;
    assign initiator_tdata  = out_data_q;
    assign initiator_tlast  = out_last_q;
    assign frame_count      = frame_cnt_q;
    assign escape_count     = esc_cnt_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_frame_encoder.sv
// -----------------------------------------------------------------------------
// Testbench for axis_frame_encoder. Two instances share the input stream:
// dut0 uses the default parameters, dut1 uses XOR_MASK=8'h20 and 2-bit counters
// so that masking and counter wrap are observed on the same traffic. Expected
// output streams are built from the framing rules on whole packets.
// -----------------------------------------------------------------------------
module tb_axis_frame_encoder;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       target_tvalid;
    logic [7:0] target_tdata;
    logic       target_tlast;
    logic       initiator_tready;

    logic        t_rdy0, o_vld0, o_lst0, busy0;
    logic [7:0]  o_dat0;
    logic [15:0] fc0, ec0;
    logic        t_rdy1, o_vld1, o_lst1, busy1;
    logic [7:0]  o_dat1;
    logic [1:0]  fc1, ec1;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;   // 0 always ready, 1 toggle, 2 random
    int busy_low = 0;
    int exp_frames = 0;
    int exp_escapes = 0;

    logic [8:0] exp0[$];
    logic [8:0] exp1[$];
    logic [8:0] got0[$];
    logic [8:0] got1[$];

    logic       stall0, stall1;
    logic [8:0] held0, held1;

    always #5 aclk = ~aclk;

    axis_frame_encoder dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .target_tvalid(target_tvalid), .target_tready(t_rdy0),
        .target_tdata(target_tdata), .target_tlast(target_tlast),
        .initiator_tvalid(o_vld0), .initiator_tready(initiator_tready),
        .initiator_tdata(o_dat0), .initiator_tlast(o_lst0),
        .frame_count(fc0), .escape_count(ec0), .busy(busy0)
    );

    axis_frame_encoder #(.XOR_MASK(8'h20), .CNT_WIDTH(2)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .target_tvalid(target_tvalid), .target_tready(t_rdy1),
        .target_tdata(target_tdata), .target_tlast(target_tlast),
        .initiator_tvalid(o_vld1), .initiator_tready(initiator_tready),
        .initiator_tdata(o_dat1), .initiator_tlast(o_lst1),
        .frame_count(fc1), .escape_count(ec1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: START, payload with escapes, STOP(last).
    task automatic model_packet(input logic [7:0] pkt[$]);
        exp0.push_back({1'b0, 8'h7D});
        exp1.push_back({1'b0, 8'h7D});
        foreach (pkt[i]) begin
            if (pkt[i] == 8'h7D || pkt[i] == 8'h7E || pkt[i] == 8'h7F) begin
                exp0.push_back({1'b0, 8'h7F});
                exp1.push_back({1'b0, 8'h7F});
                exp0.push_back({1'b0, pkt[i]});
                exp1.push_back({1'b0, pkt[i] ^ 8'h20});
                exp_escapes++;
            end else begin
                exp0.push_back({1'b0, pkt[i]});
                exp1.push_back({1'b0, pkt[i]});
            end
        end
        exp0.push_back({1'b1, 8'h7E});
        exp1.push_back({1'b1, 8'h7E});
        exp_frames++;
    endtask

    // Drive a packet; inputs change 1 time unit after posedge, ready sampled at negedge.
    task automatic send_packet(input logic [7:0] pkt[$], input logic last_flag,
                               output logic first_rdy);
        first_rdy = 1'b1;
        for (int i = 0; i < pkt.size(); i++) begin
            int  n;
            bit  done;
            target_tvalid = 1'b1;
            target_tdata  = pkt[i];
            target_tlast  = last_flag && (i == pkt.size() - 1);
            n = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge aclk);
                if (!busy0) busy_low++;
                if (i == 0 && n == 0) first_rdy = t_rdy0;
                if (t_rdy0) begin
                    done = 1'b1;
                end else begin
                    n++;
                    if (n > 100) begin
                        chk("src_timeout", 32'd1, 32'd0);
                        done = 1'b1;
                    end
                end
            end
            @(posedge aclk);
            #1;
        end
        target_tvalid = 1'b0;
        target_tlast  = 1'b0;
    endtask

    // Wait for all expected bytes, then compare streams and counters.
    task automatic drain_check(input string tag);
        int n;
        n = 0;
        while ((got0.size() < exp0.size() || got1.size() < exp1.size()) && n < 500) begin
            @(negedge aclk);
            n++;
        end
        repeat (4) @(negedge aclk);
        chk({tag, "_len0"}, got0.size(), exp0.size());
        chk({tag, "_len1"}, got1.size(), exp1.size());
        for (int k = 0; k < exp0.size(); k++) begin
            if (k < got0.size()) chk({tag, "_byte0"}, {23'd0, got0[k]}, {23'd0, exp0[k]});
        end
        for (int k = 0; k < exp1.size(); k++) begin
            if (k < got1.size()) chk({tag, "_byte1"}, {23'd0, got1[k]}, {23'd0, exp1[k]});
        end
        chk({tag, "_frames0"}, {16'd0, fc0}, {16'd0, exp_frames[15:0]});
        chk({tag, "_escapes0"}, {16'd0, ec0}, {16'd0, exp_escapes[15:0]});
        chk({tag, "_frames1"}, {30'd0, fc1}, {30'd0, exp_frames[1:0]});
        chk({tag, "_escapes1"}, {30'd0, ec1}, {30'd0, exp_escapes[1:0]});
        chk({tag, "_idle"}, {31'd0, busy0}, 32'd0);
        exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vld"}, {30'd0, o_vld0, o_vld1}, 32'd0);
        chk({tag, "_dat"}, {16'd0, o_dat0, o_dat1}, 32'd0);
        chk({tag, "_lst"}, {30'd0, o_lst0, o_lst1}, 32'd0);
        chk({tag, "_rdy"}, {30'd0, t_rdy0, t_rdy1}, 32'd0);
        chk({tag, "_busy"}, {30'd0, busy0, busy1}, 32'd0);
        chk({tag, "_cnt0"}, {fc0, ec0}, 32'd0);
        chk({tag, "_cnt1"}, {28'd0, fc1, ec1}, 32'd0);
    endtask

    // Sink: ready pattern updated just after each rising edge.
    initial begin
        initiator_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (ready_mode)
                0:       initiator_tready = 1'b1;
                1:       initiator_tready = ~initiator_tready;
                default: initiator_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: capture output handshakes and check stall stability.
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall0 <= 1'b0;
            stall1 <= 1'b0;
        end else begin
            if (stall0) chk("stall_hold0", {22'd0, o_vld0, o_lst0, o_dat0}, {22'd0, 1'b1, held0});
            if (stall1) chk("stall_hold1", {22'd0, o_vld1, o_lst1, o_dat1}, {22'd0, 1'b1, held1});
            if (o_vld0 && initiator_tready) got0.push_back({o_lst0, o_dat0});
            if (o_vld1 && initiator_tready) got1.push_back({o_lst1, o_dat1});
            stall0 <= o_vld0 && !initiator_tready;
            stall1 <= o_vld1 && !initiator_tready;
            held0  <= {o_lst0, o_dat0};
            held1  <= {o_lst1, o_dat1};
        end
    end

    initial begin
        logic [7:0] p[$];
        logic       fr;

        aresetn = 1'b0;
        target_tvalid = 1'b0;
        target_tdata = 8'h00;
        target_tlast = 1'b0;
        repeat (3) @(negedge aclk);
        check_all_zero("reset");
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 1: plain packet; no input accepted on the START cycle.
        ready_mode = 0;
        p = '{8'h01, 8'h02, 8'h03};
        model_packet(p);
        send_packet(p, 1'b1, fr);
        chk("t1_start_tready", {31'd0, fr}, 32'd0);
        drain_check("t1");

        // 2: every byte needs escaping.
        p = '{8'h7F, 8'h7D, 8'h7E};
        model_packet(p);
        send_packet(p, 1'b1, fr);
        drain_check("t2");

        // 3: single escaped byte is also the last byte.
        p = '{8'h7E};
        model_packet(p);
        send_packet(p, 1'b1, fr);
        drain_check("t3");

        // 4: test 2 stream under a toggling sink.
        ready_mode = 1;
        p = '{8'h7F, 8'h7D, 8'h7E};
        model_packet(p);
        send_packet(p, 1'b1, fr);
        drain_check("t4");
        ready_mode = 0;
        repeat (2) begin @(posedge aclk); #1; end

        // 5: back-to-back frames with the source always valid.
        p = '{8'h7F};
        model_packet(p);
        send_packet(p, 1'b1, fr);
        busy_low = 0;
        p = '{8'hAA};
        model_packet(p);
        send_packet(p, 1'b1, fr);
        chk("t5_busy_gap", busy_low, 32'd1);
        drain_check("t5");

        // Random packets with a random sink and random gaps.
        ready_mode = 2;
        for (int pk = 0; pk < 20; pk++) begin
            int len;
            len = $urandom_range(1, 6);
            p.delete();
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) p.push_back(8'h7D + 8'($urandom_range(0, 2)));
                else p.push_back(8'($urandom_range(0, 255)));
            end
            model_packet(p);
            send_packet(p, 1'b1, fr);
            repeat ($urandom_range(0, 3)) begin @(posedge aclk); #1; end
        end
        drain_check("rand");
        ready_mode = 0;
        repeat (2) begin @(posedge aclk); #1; end

        // 6: reset after START plus one byte discards the frame.
        p = '{8'h11};
        send_packet(p, 1'b0, fr);
        aresetn = 1'b0;
        #1;
        check_all_zero("t6_reset");
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
        exp_frames = 0;
        exp_escapes = 0;
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        p = '{8'h55};
        model_packet(p);
        send_packet(p, 1'b1, fr);
        chk("t6_start_tready", {31'd0, fr}, 32'd0);
        drain_check("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
